// File: rtl/adc_pll_lock_supervisor.sv
// adc_pll_lock_supervisor: sequences the ADC PLL reset, qualifies lock, and gates the sampling-domain reset
module adc_pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_async,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       domain_rst_n,
  output logic       pll_ok,
  output logic       lock_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);
  localparam logic [2:0] RESET_PLL = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] QUALIFY   = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAIL      = 3'd4;
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_DONE = SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  logic [2:0]    state;
  logic [PW-1:0] pulse_cnt;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] timer;
  logic          lock_meta, lock_s;
  logic [SW-1:0] stable_inc;
  logic [3:0]    retry_inc;
  logic          stable_done, timeout, give_up;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {lock_meta, lock_s} <= 2'b00;
    else {lock_meta, lock_s} <= {pll_locked_async, lock_meta};
  always_comb begin
    stable_inc  = stable_cnt + 1'b1;
    stable_done = lock_s && stable_inc == STABLE_DONE;
    timeout     = timer == TIMER_LAST;
    retry_inc   = retry_cnt == 4'hf ? retry_cnt : retry_cnt + 1'b1;
    give_up     = MAX_RETRIES != 0 && retry_inc == 4'(MAX_RETRIES);
  end
  // The first synced-high cycle in WAIT_LOCK already counts toward stability
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= RESET_PLL;
      pulse_cnt     <= '0;
      stable_cnt    <= '0;
      timer         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (state == RUN && !lock_s && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 1'b1;
      if (force_relock) begin
        state      <= RESET_PLL;
        pulse_cnt  <= '0;
        stable_cnt <= '0;
        timer      <= '0;
        retry_cnt  <= '0;
      end else case (state)
        RESET_PLL: begin
          pulse_cnt <= pulse_cnt == PULSE_LAST ? '0 : pulse_cnt + 1'b1;
          state     <= pulse_cnt == PULSE_LAST ? WAIT_LOCK : RESET_PLL;
        end
        WAIT_LOCK, QUALIFY: begin
          timer      <= timer + 1'b1;
          stable_cnt <= lock_s ? stable_inc : '0;
          state      <= lock_s ? QUALIFY : WAIT_LOCK;
          if (stable_done) begin
            state      <= RUN;
            retry_cnt  <= '0;
            timer      <= '0;
            stable_cnt <= '0;
          end else if (timeout) begin
            state      <= give_up ? FAIL : RESET_PLL;
            retry_cnt  <= retry_inc;
            timer      <= '0;
            stable_cnt <= '0;
          end
        end
        RUN:     state <= lock_s ? RUN : RESET_PLL;
        FAIL:    state <= FAIL;
        default: state <= RESET_PLL;
      endcase
    end
  assign pll_rst      = state == RESET_PLL || state == FAIL;
  assign domain_rst_n = state == RUN;
  assign pll_ok       = state == RUN;
  assign lock_fail    = state == FAIL;
endmodule
